// File: rtl/coeffs_load_sequencer.sv
// Streams a burst of coefficients into consecutive working-bank addresses. It then commits the
// bank to the shadow copy with a single coeffs_en pulse, aligned to a sample boundary.
module coeffs_load_sequencer #(
  parameter int NUM_COEFFS = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic                     cfg_start,
  input  logic [ADDR_W-1:0]        cfg_base_addr,
  input  logic [ADDR_W:0]          cfg_len,
  input  logic                     cfg_abort,
  input  logic                     sample_boundary,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        write_address,
  output logic signed [DATA_W-1:0] coeffs_in,
  output logic                     write_enable,
  output logic                     coeffs_en,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  // Stream handshake: a beat transfers on a clk edge where in_valid & in_ready & clk_enable.
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD        = 2'd1,
    WAIT_COMMIT = 2'd2
  } state_t;

  localparam logic [ADDR_W+1:0] NUM_C   = (ADDR_W + 2)'(NUM_COEFFS);
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [ADDR_W:0]            remaining_q, remaining_d;
  logic [ADDR_W-1:0]          write_address_q, write_address_d;
  logic signed [DATA_W-1:0]   coeffs_in_q, coeffs_in_d;
  logic                       write_enable_q, write_enable_d;
  logic                       coeffs_en_q, coeffs_en_d;
  logic                       done_q, done_d;
  logic                       cfg_err_q, cfg_err_d;

  logic [ADDR_W+1:0]          end_addr;
  logic                       cfg_ok;

  assign end_addr = {2'b00, cfg_base_addr} + {1'b0, cfg_len};
  assign cfg_ok   = (cfg_len != '0) && ({1'b0, cfg_len} <= NUM_C) && (end_addr <= NUM_C);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    write_address_d = write_address_q;
    coeffs_in_d     = coeffs_in_q;
    write_enable_d  = write_enable_q;
    // Pulses feed the shadow bank, which ignores clk_enable, so they always clear next edge.
    coeffs_en_d     = 1'b0;
    done_d          = 1'b0;
    cfg_err_d       = 1'b0;
    if (clk_enable) begin
      if (cfg_abort) begin
        state_d        = IDLE;
        write_enable_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cfg_start) begin
              if (cfg_ok) begin
                addr_d      = cfg_base_addr;
                remaining_d = cfg_len;
                state_d     = LOAD;
              end else begin
                cfg_err_d = 1'b1;
              end
            end
          end
          LOAD: begin
            if (in_valid) begin
              write_enable_d  = 1'b1;
              write_address_d = addr_q;
              coeffs_in_d     = in_data;
              remaining_d     = remaining_q - REM_ONE;
              // The final beat leaves addr in place so it never wraps past the top slot.
              if (remaining_q == REM_ONE) state_d = WAIT_COMMIT;
              else                        addr_d  = addr_q + ADDR_ONE;
            end else begin
              write_enable_d = 1'b0;
            end
          end
          WAIT_COMMIT: begin
            write_enable_d = 1'b0;
            if (sample_boundary && !write_enable_q) begin
              coeffs_en_d = 1'b1;
              done_d      = 1'b1;
              state_d     = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      write_address_q <= '0;
      coeffs_in_q     <= '0;
      write_enable_q  <= 1'b0;
      coeffs_en_q     <= 1'b0;
      done_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      write_address_q <= write_address_d;
      coeffs_in_q     <= coeffs_in_d;
      write_enable_q  <= write_enable_d;
      coeffs_en_q     <= coeffs_en_d;
      done_q          <= done_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  assign in_ready      = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign write_address = write_address_q;
  assign coeffs_in     = coeffs_in_q;
  assign write_enable  = write_enable_q;
  assign coeffs_en     = coeffs_en_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_coeffs_load_sequencer.sv
// Bench for coeffs_load_sequencer: expected {address, data} writes are queued when a burst is
// started and popped whenever the downstream bank would sample a write.
module tb_coeffs_load_sequencer;

  localparam int NUM_COEFFS = 64;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 16;
  localparam int EXP_W      = ADDR_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              clk_enable = 1'b0;
  logic              cfg_start = 1'b0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [ADDR_W:0]   cfg_len = '0;
  logic              cfg_abort = 1'b0;
  logic              sample_boundary = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] coeffs_in;
  logic              write_enable;
  logic              coeffs_en;
  logic              busy;
  logic              done;
  logic              cfg_err;

  coeffs_load_sequencer #(
    .NUM_COEFFS(NUM_COEFFS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_abort(cfg_abort),
    .sample_boundary(sample_boundary), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .write_address(write_address), .coeffs_in(coeffs_in),
    .write_enable(write_enable), .coeffs_en(coeffs_en), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] beat_data[NUM_COEFFS];
  int n_checks = 0, n_fail = 0;
  int commit_cnt = 0, err_cnt = 0, write_cnt = 0;
  int exp_writes = 0, exp_commits = 0, exp_errs = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard: a write lands on any edge where write_enable and clk_enable are both high
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst) begin
      if (write_enable && clk_enable) begin
        write_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~{write_address, coeffs_in};
        check("write", 32'({write_address, coeffs_in}), 32'(e));
      end
      if (coeffs_en) commit_cnt++;
      if (cfg_err) err_cnt++;
      if (coeffs_en || done) check("done_with_coeffs_en", 32'(done), 32'(coeffs_en));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data(input bit ramp);
    for (int i = 0; i < NUM_COEFFS; i++)
      beat_data[i] = ramp ? DATA_W'(i - 32) : DATA_W'($urandom_range(0, 65535));
  endtask

  task automatic push_exp(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(base + i), beat_data[i]});
    exp_writes += n;
  endtask

  task automatic start_burst(input int base, input int len, input bit ok);
    clk_enable    = 1'b1;
    cfg_base_addr = ADDR_W'(base);
    cfg_len       = (ADDR_W + 1)'(len);
    cfg_start     = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("start_busy", 32'(busy), 32'(ok));
    check("start_cfg_err", 32'(cfg_err), 32'(!ok));
  endtask

  task automatic send_beats(input int n, input bit toggle, input bit sb_last);
    int idx = 0;
    int c = 0;
    bit acc;
    while (idx < n && c < 1000) begin
      in_valid        = toggle ? (c % 2 == 0) : 1'b1;
      clk_enable      = toggle ? (c % 3 != 2) : 1'b1;
      in_data         = beat_data[idx];
      sample_boundary = sb_last && (idx == n - 1);
      acc = in_valid && in_ready && clk_enable;
      tick();
      if (acc) idx++;
      c++;
    end
    in_valid        = 1'b0;
    sample_boundary = 1'b0;
    clk_enable      = 1'b1;
    check("beats_sent", 32'(idx), 32'(n));
  endtask

  task automatic commit_now();
    sample_boundary = 1'b0;
    tick();
    check("pre_commit_coeffs_en", 32'(coeffs_en), 32'd0);
    sample_boundary = 1'b1;
    tick();
    sample_boundary = 1'b0;
    exp_commits++;
    check("commit_coeffs_en", 32'(coeffs_en), 32'd1);
    check("commit_done", 32'(done), 32'd1);
    check("commit_busy", 32'(busy), 32'd0);
    clk_enable = 1'b0;
    tick();
    check("coeffs_en_clears", 32'(coeffs_en), 32'd0);
    clk_enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lost;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", 32'({write_address, coeffs_in, write_enable, coeffs_en, done, cfg_err}), 32'd0);
    rst = 1'b0;
    clk_enable = 1'b1;
    tick();

    // full bank, back-to-back ramp
    fill_data(1'b1);
    push_exp(0, 64);
    start_burst(0, 64, 1'b1);
    send_beats(64, 1'b0, 1'b0);
    check("full_in_ready_low", 32'(in_ready), 32'd0);
    commit_now();
    check("full_write_count", 32'(write_cnt), 32'd64);

    // range checks
    start_burst(60, 5, 1'b0);
    exp_errs++;
    clk_enable = 1'b0;
    tick();
    check("cfg_err_clears", 32'(cfg_err), 32'd0);
    start_burst(3, 0, 1'b0);
    exp_errs++;
    fill_data(1'b0);
    push_exp(60, 4);
    start_burst(60, 4, 1'b1);
    send_beats(4, 1'b0, 1'b0);
    commit_now();

    // gapped valid and clock enable
    fill_data(1'b0);
    push_exp(10, 12);
    start_burst(10, 12, 1'b1);
    send_beats(12, 1'b1, 1'b0);
    commit_now();

    // last beat coincides with sample_boundary
    fill_data(1'b0);
    push_exp(0, 3);
    start_burst(0, 3, 1'b1);
    send_beats(3, 1'b0, 1'b1);
    check("sb_same_cycle_no_commit", 32'(coeffs_en), 32'd0);
    check("sb_same_cycle_busy", 32'(busy), 32'd1);
    commit_now();

    // abort mid-burst; the beat offered with abort must not be written
    fill_data(1'b0);
    push_exp(0, 10);
    start_burst(0, 20, 1'b1);
    send_beats(10, 1'b0, 1'b0);
    cfg_abort = 1'b1;
    in_valid  = 1'b1;
    in_data   = beat_data[10];
    tick();
    cfg_abort = 1'b0;
    in_valid  = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_write_enable", 32'(write_enable), 32'd0);
    sample_boundary = 1'b1;
    tick();
    sample_boundary = 1'b0;
    check("abort_no_commit", 32'(coeffs_en), 32'd0);
    fill_data(1'b0);
    push_exp(5, 2);
    start_burst(5, 2, 1'b1);
    send_beats(2, 1'b0, 1'b0);
    commit_now();

    // reset while a commit is pending; the unsampled final write is lost with it
    fill_data(1'b0);
    push_exp(20, 2);
    start_burst(20, 2, 1'b1);
    send_beats(2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_outputs", 32'({write_address, coeffs_in, write_enable, coeffs_en, done, cfg_err}), 32'd0);
    lost = exp_q.size();
    check("mid_rst_lost_writes", 32'(lost), 32'd1);
    exp_q.delete();
    exp_writes -= lost;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_boundary = (i % 2 == 0);
      tick();
      check("post_rst_no_commit", 32'(coeffs_en), 32'd0);
    end
    sample_boundary = 1'b0;
    repeat (2) tick();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("total_writes", 32'(write_cnt), 32'(exp_writes));
    check("total_commits", 32'(commit_cnt), 32'(exp_commits));
    check("total_cfg_errs", 32'(err_cnt), 32'(exp_errs));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
